// File: rtl/enigma_kb_pkg.sv
// Shared types, constants and the Set-2 scancode lookup for the Enigma keyboard front end.
package enigma_kb_pkg;

  localparam int KEY_W = 6;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } kb_state_e;

  // Letters map to 1..26, digits (when enabled) to 27..36, anything else to 0.
  function automatic logic [KEY_W-1:0] sc2key(input logic [7:0] sc, input bit map_digits);
    logic [KEY_W-1:0] k;
    k = '0;
    case (sc)
      8'h1C: k = 6'd1;   8'h32: k = 6'd2;   8'h21: k = 6'd3;   8'h23: k = 6'd4;
      8'h24: k = 6'd5;   8'h2B: k = 6'd6;   8'h34: k = 6'd7;   8'h33: k = 6'd8;
      8'h43: k = 6'd9;   8'h3B: k = 6'd10;  8'h42: k = 6'd11;  8'h4B: k = 6'd12;
      8'h3A: k = 6'd13;  8'h31: k = 6'd14;  8'h44: k = 6'd15;  8'h4D: k = 6'd16;
      8'h15: k = 6'd17;  8'h2D: k = 6'd18;  8'h1B: k = 6'd19;  8'h2C: k = 6'd20;
      8'h3C: k = 6'd21;  8'h2A: k = 6'd22;  8'h1D: k = 6'd23;  8'h22: k = 6'd24;
      8'h35: k = 6'd25;  8'h1A: k = 6'd26;
      default: k = '0;
    endcase
    if (map_digits) begin
      case (sc)
        8'h45: k = 6'd27;  8'h16: k = 6'd28;  8'h1E: k = 6'd29;  8'h26: k = 6'd30;
        8'h25: k = 6'd31;  8'h2E: k = 6'd32;  8'h36: k = 6'd33;  8'h3D: k = 6'd34;
        8'h3E: k = 6'd35;  8'h46: k = 6'd36;
        default: ;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Scancode input, decoded-key stream and FIFO status between the receiver, decoder and rotor datapath.
interface ps2_key_decoder_if #(
  parameter int DEPTH = 4
);
  import enigma_kb_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       sc_data;
  logic             sc_valid;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;
  logic             overflow;
  logic [LVL_W-1:0] level;

  modport master (
    input  sc_data, sc_valid, key_ready,
    output key_code, key_valid, overflow, level
  );

  modport slave (
    output sc_data, sc_valid, key_ready,
    input  key_code, key_valid, overflow, level
  );

endinterface

// File: rtl/key_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; head reads as 0 when empty.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int KEY_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [KEY_W-1:0]         data_i,
  input  logic                     pop_i,
  output logic [KEY_W-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable because empty_o masks the head.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 make/break/extended tracker feeding a key FIFO toward the rotor datapath.
// Optional typematic repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_decoder
  import enigma_kb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAP_DIGITS = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  ps2_key_decoder_if.master      bus
);

  kb_state_e        state_q, state_d;
  logic [KEY_W-1:0] decoded;
  logic             make_stb;
  logic             repeat_hit;
  logic             push_req;
  logic             push_accept;
  logic             pop;
  logic             fifo_full, fifo_empty;
  logic             overflow_q, overflow_d;

  assign decoded = sc2key(bus.sc_data, MAP_DIGITS != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    make_stb = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else if (bus.sc_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.sc_data == SC_BREAK)    state_d = S_BRK;
          else if (bus.sc_data == SC_EXT) state_d = S_EXT;
          else                            make_stb = 1'b1;
        end
        S_BRK:     state_d = S_IDLE;
        S_EXT:     state_d = (bus.sc_data == SC_BREAK) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  assign pop         = bus.key_ready && !fifo_empty;
  assign push_req    = make_stb && (decoded != '0) && !repeat_hit;
  assign push_accept = push_req && (!fifo_full || pop);
  assign overflow_d  = push_req && fifo_full && !pop && !flush;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [KEY_W-1:0] last_make_q, last_make_d;
  logic             break_stb;

  assign break_stb  = bus.sc_valid && (state_q == S_BRK);
  assign repeat_hit = (decoded == last_make_q);

  // Only keys that actually enter the FIFO arm the repeat filter; releasing that key disarms it.
  always_comb begin
    last_make_d = last_make_q;
    if (flush)                                        last_make_d = '0;
    else if (push_accept)                             last_make_d = decoded;
    else if (break_stb && (decoded == last_make_q))   last_make_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_make_q <= '0;
    else        last_make_q <= last_make_d;
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push_accept),
    .data_i  (decoded),
    .pop_i   (pop),
    .data_o  (bus.key_code),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (bus.level)
  );

  assign bus.key_valid = !fifo_empty;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (digits unmapped / mapped) against a queue-based key model.
module tb_ps2_key_decoder;
  import enigma_kb_pkg::*;

  localparam int DEPTH = 4;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] sc_data = 8'h00;
  logic       sc_valid = 1'b0;
  logic       key_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  ps2_key_decoder_if #(.DEPTH(DEPTH)) bus0 ();
  ps2_key_decoder_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus0.sc_data = sc_data;  assign bus0.sc_valid = sc_valid;  assign bus0.key_ready = key_ready;
  assign bus1.sc_data = sc_data;  assign bus1.sc_valid = sc_valid;  assign bus1.key_ready = key_ready;

  ps2_key_decoder #(.DEPTH(DEPTH), .MAP_DIGITS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0)
  );
  ps2_key_decoder #(.DEPTH(DEPTH), .MAP_DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Scancode tables in key order: A..Z, then 0..9.
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int ref_code(logic [7:0] b, bit md);
    for (int i = 0; i < 26; i++) if (letters[i] == b) return i + 1;
    if (md) for (int i = 0; i < 10; i++) if (digits[i] == b) return 27 + i;
    return 0;
  endfunction

  // Model: per instance, a list of queued keys, the pending prefix bytes and the repeat memory.
  int mdata [2][DEPTH];
  int mcnt  [2];
  bit saw_f0 [2];
  bit saw_e0 [2];
  int last_key [2];
  bit m_ovf [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_step(int d);
    bit pop, push;
    int code;
    pop  = (mcnt[d] > 0) && key_ready;
    push = 1'b0;
    code = 0;
    m_ovf[d] = 1'b0;
    if (flush) begin
      mcnt[d] = 0; saw_f0[d] = 1'b0; saw_e0[d] = 1'b0; last_key[d] = 0;
      return;
    end
    if (sc_valid) begin
      code = ref_code(sc_data, d == 1);
      if (saw_f0[d]) begin
        if (!saw_e0[d] && FILTER && code == last_key[d]) last_key[d] = 0;
        saw_f0[d] = 1'b0;
        saw_e0[d] = 1'b0;
      end else if (sc_data == 8'hF0) saw_f0[d] = 1'b1;
      else if (saw_e0[d])           saw_e0[d] = 1'b0;
      else if (sc_data == 8'hE0)    saw_e0[d] = 1'b1;
      else if (code != 0 && !(FILTER && code == last_key[d])) push = 1'b1;
    end
    if (push && mcnt[d] == DEPTH && !pop) begin
      m_ovf[d] = 1'b1;
      push = 1'b0;
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mdata[d][i] = mdata[d][i+1];
      mcnt[d]--;
    end
    if (push) begin
      mdata[d][mcnt[d]] = code;
      mcnt[d]++;
      last_key[d] = code;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mcnt[d] = 0; saw_f0[d] = 1'b0; saw_e0[d] = 1'b0; last_key[d] = 0; m_ovf[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // Continuous comparison on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    check("dut0 key_valid", int'(bus0.key_valid), int'(mcnt[0] > 0));
    check("dut0 key_code",  int'(bus0.key_code),  (mcnt[0] > 0) ? mdata[0][0] : 0);
    check("dut0 level",     int'(bus0.level),     mcnt[0]);
    check("dut0 overflow",  int'(bus0.overflow),  int'(m_ovf[0]));
    check("dut1 key_valid", int'(bus1.key_valid), int'(mcnt[1] > 0));
    check("dut1 key_code",  int'(bus1.key_code),  (mcnt[1] > 0) ? mdata[1][0] : 0);
    check("dut1 level",     int'(bus1.level),     mcnt[1]);
    check("dut1 overflow",  int'(bus1.overflow),  int'(m_ovf[1]));
  end

  task automatic send(input logic [7:0] b);
    sc_data  = b;
    sc_valid = 1'b1;
    @(posedge clk); #1;
    sc_valid = 1'b0;
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
  endtask

  task automatic pop_expect(input int exp);
    check("head before pop", int'(bus0.key_code), exp);
    pop_one();
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset level",     int'(bus0.level), 0);
    check("reset key_valid", int'(bus0.key_valid), 0);
    check("reset key_code",  int'(bus0.key_code), 0);
    check("reset overflow",  int'(bus0.overflow), 0);

    // Make A: visible the cycle after the strobe; its break pushes nothing.
    send(8'h1C);
    check("make A valid", int'(bus0.key_valid), 1);
    check("make A code",  int'(bus0.key_code), 1);
    pop_one();
    check("empty after pop", int'(bus0.level), 0);
    send(8'hF0); send(8'h1C);
    check("break pushes nothing", int'(bus0.level), 0);

    // Extended sequences never output; digit 0 only with the digit map.
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    check("extended no push", int'(bus1.level), 0);
    send(8'h45);
    check("digit unmapped level", int'(bus0.level), 0);
    check("digit mapped code",    int'(bus1.key_code), 27);
    check("digit mapped level",   int'(bus1.level), 1);
    pop_one();

    // Fill to DEPTH, then one drop.
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    check("full level",     int'(bus0.level), 4);
    check("overflow pulse", int'(bus0.overflow), 1);

    // Push Z with simultaneous pop while full.
    sc_data = 8'h1A; sc_valid = 1'b1; key_ready = 1'b1;
    @(posedge clk); #1;
    sc_valid = 1'b0; key_ready = 1'b0;
    check("overflow one cycle",    int'(bus0.overflow), 0);
    check("push+pop full level",   int'(bus0.level), 4);
    pop_expect(2); pop_expect(3); pop_expect(4); pop_expect(26);
    check("drained", int'(bus0.level), 0);

    // Typematic repeat of A with a release in the middle.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    check("typematic level", int'(bus0.level), FILTER ? 2 : 4);
    check("typematic head",  int'(bus0.key_code), 1);
    flush_cycle();
    check("flush empties", int'(bus0.level), 0);

    // Reset between F0 and its break byte: the next byte is a make.
    send(8'hF0);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("mid reset level", int'(bus0.level), 0);
    send(8'h32);
    check("make after reset code",  int'(bus0.key_code), 2);
    check("make after reset level", int'(bus0.level), 1);
    flush_cycle();

    // Flush wins over a pending push into a full FIFO; no overflow.
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    sc_data = 8'h24; sc_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    sc_valid = 1'b0; flush = 1'b0;
    check("flush vs push level",    int'(bus0.level), 0);
    check("flush vs push overflow", int'(bus0.overflow), 0);
    check("flush vs push valid",    int'(bus0.key_valid), 0);

    // Randomised traffic; the negedge compare carries the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      sc_valid = ($urandom_range(2, 0) != 0);
      r = $urandom_range(7, 0);
      if (r < 4)       sc_data = letters[$urandom_range(25, 0)];
      else if (r == 4) sc_data = 8'hF0;
      else if (r == 5) sc_data = 8'hE0;
      else if (r == 6) sc_data = digits[$urandom_range(9, 0)];
      else             sc_data = 8'($urandom);
      if (cyc < 2000) key_ready = ($urandom_range(3, 0) == 0);
      else            key_ready = ($urandom_range(3, 0) != 0);
      flush = ($urandom_range(199, 0) == 0);
      @(posedge clk); #1;
    end
    sc_valid = 1'b0; flush = 1'b0; key_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("final drain", int'(bus0.level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sequential successor to the combinational scancode-to-letter decoder. Consumes the PS/2 Set-2 byte stream from the keyboard receiver, tracks make/break/extended prefixes, maps letter (and optionally digit) make codes to a 6-bit key index, and buffers decoded keys in a small FIFO with a valid/ready output toward the Enigma rotor datapath.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `MAP_DIGITS`, 0: 1 maps digit keys 0..9 to codes 27..36; 0 leaves digit keys unmapped.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sc_data` in 8: scancode byte from the PS/2 receiver.
- `sc_valid` in 1: one-cycle strobe; `sc_data` is valid this cycle.
- `flush` in 1: synchronous clear of the FIFO and the FSM.
- `key_code` out 6: head-of-FIFO key index (A=1 .. Z=26, digits 27..36); 0 when empty.
- `key_valid` out 1: FIFO not empty.
- `key_ready` in 1: consumer accepts the head when `key_valid` is high.
- `overflow` out 1: one-cycle pulse when a decoded key is dropped because the FIFO is full.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Letter map, fixed: 1C=A(1), 32=B, 21=C, 23=D, 24=E, 2B=F, 34=G, 33=H, 43=I, 3B=J, 42=K, 4B=L, 3A=M, 31=N, 44=O, 4D=P, 15=Q, 2D=R, 1B=S, 2C=T, 3C=U, 2A=V, 1D=W, 22=X, 35=Y, 1A=Z(26).
- Digit map, applied only when `MAP_DIGITS`=1: 45=0(27), 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9(36).
- Every other byte maps to 0. A code of 0 is never pushed.
- The FSM advances only on cycles with `sc_valid`=1.
- S_IDLE:
  - F0 goes to S_BRK.
  - E0 goes to S_EXT.
  - Any other byte is a make code: decode it, push if nonzero, stay in S_IDLE.
- S_BRK: any byte is a break code. It is decoded for the filter only, nothing is pushed, and the FSM returns to S_IDLE.
- S_EXT: F0 goes to S_EXT_BRK. Any other byte is discarded and the FSM returns to S_IDLE.
- S_EXT_BRK: any byte is discarded and the FSM returns to S_IDLE. Extended keys never produce output.
- FIFO behaviour:
  - First-word-fall-through: `key_code` shows the head entry.
  - Pop happens when `key_valid` and `key_ready` are both high.
  - Push while full, with no pop in the same cycle: the key is dropped, `overflow` pulses, and the contents are unchanged.
  - Push and pop in the same cycle while full: both take effect and `level` stays at DEPTH.
  - Push and pop in the same cycle while empty: the FIFO goes non-empty next cycle. There is no bypass.
- `flush`:
  - Empties the FIFO, returns the FSM to S_IDLE and clears the filter register.
  - Takes priority over a push or pop in the same cycle.
  - `overflow` is 0 during a flush cycle.

## Timing
- Reset values: FSM=S_IDLE, FIFO empty, `key_valid`=0, `key_code`=0, `overflow`=0, `level`=0, filter register=0.
- Latency: a make byte strobed in cycle N gives `key_valid`=1 in cycle N+1 when the FIFO was empty.
- `overflow` is registered and asserts in cycle N+1 for a drop in cycle N.
- Pointers wrap modulo DEPTH.
- `level` counts 0..DEPTH inclusive; no saturation logic is needed beyond this range.
- Reset asserted mid-sequence (for example after F0 and before the break byte) returns everything to reset values. The next byte is treated as a make.
- No throughput limit: `sc_valid` may be asserted on consecutive cycles.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - A 6-bit `last_make` register holds the most recent pushed code.
  - A make equal to `last_make` is not pushed, which suppresses auto-repeat.
  - A break of that same code clears `last_make` to 0.
  - Breaks of other codes leave it unchanged.
- `PS2_TYPEMATIC_FILTER_EN` undefined: every nonzero make is pushed and the register is not instantiated.

## Structure
- Package `enigma_kb_pkg` holds:
  - FSM state enum (S_IDLE, S_BRK, S_EXT, S_EXT_BRK).
  - Constants SC_BREAK=8'hF0 and SC_EXT=8'hE0.
  - Parameter KEY_W=6.
  - Function `sc2key(byte, map_digits)` returning the 6-bit code.
- Sub-module `key_fifo`: parameterised synchronous FIFO (DEPTH, KEY_W) with FWFT output, level and full/empty flags.

## Test plan
- Make 1C, then F0 1C -> `key_code`=1 with `key_valid` at N+1. After a pop the FIFO is empty; the break pushes nothing.
- E0 1C, E0 F0 1C, and 45 with MAP_DIGITS=0 -> no push and `level` stays 0. Repeat 45 with MAP_DIGITS=1 -> `key_code`=27.
- DEPTH=4, `key_ready`=0, makes 1C 32 21 23 24 -> `level`=4 and one `overflow` pulse. Pops then yield 1,2,3,4.
- Full FIFO, push 1A with a simultaneous pop -> `level` stays 4 and the tail entry is 26.
- Filter enabled, 1C 1C 1C F0 1C 1C -> exactly two A entries. Filter disabled -> four A entries.
- F0 then async `rst_n` pulse, then 32 -> `key_code`=2 pushed as a make. `flush` while a push is pending -> `level`=0.
